// File: rtl/brick_game_pkg.sv
// Shared definitions for the brick shooter game-flow controller.
package brick_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int unsigned SCORE_W         = 10;
  localparam int unsigned SCORE_PER_BRICK = 10;
  localparam int unsigned SCORE_MAX       = 1023;

  // Adds one brick's worth of points, clamping at the top of the score range.
  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(SCORE_PER_BRICK);
    return (sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/brick_game_ctrl_btn_edge.sv
// Two-flop synchronizer for a raw button, followed by a registered rising-edge pulse.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 3'b000;
      o_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_btn};
      o_pulse <= r_sync[1] & ~r_sync[2];
    end
  end

endmodule

// File: rtl/brick_game_ctrl.sv
// Game-flow sequencer: level start, brick movement, firing, scoring and game-over/victory.
module brick_game_ctrl
  import brick_game_pkg::*;
#(
  parameter int unsigned NUM_BRICKS    = 5,
  parameter int unsigned MAX_LEVEL     = 4,
  parameter int unsigned START_SPEED   = 6,
  parameter int unsigned FIRE_COOLDOWN = 16,
  parameter int unsigned CLEAR_HOLD    = 120
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         game_tick,
  input  logic         btnS,
  input  logic         btnU,
  input  logic         brick_hit,
  input  logic         brick_reached_player,
  input  logic         player_at_top,
  input  logic         bullet_active,
  output logic [1:0]   state,
  output logic         level_init,
  output logic         fire_req,
  output logic         move_en,
  output logic         win_flight,
  output logic [3:0]   speed,
  output logic [2:0]   level,
  output logic [2:0]   bricks_left,
  output logic [9:0]   score,
  output logic         gameover,
  output logic         victory
);

  localparam int unsigned CD_W   = $clog2(FIRE_COOLDOWN + 1);
  localparam int unsigned HOLD_W = $clog2(CLEAR_HOLD + 1);

  state_e              r_state;
  logic [CD_W-1:0]     r_cooldown;
  logic [HOLD_W-1:0]   r_hold;
  logic                w_start;
  logic                w_fire;
  logic                w_fire_ok;
  logic                w_clear_exit;
  logic [3:0]          w_half_speed;

  btn_edge u_start (.i_clk(clk), .i_rst(rst), .i_btn(btnS), .o_pulse(w_start));
  btn_edge u_fire  (.i_clk(clk), .i_rst(rst), .i_btn(btnU), .o_pulse(w_fire));

  assign state        = 2'(r_state);
  assign w_fire_ok    = (r_state == ST_PLAY) && w_fire && !bullet_active && (r_cooldown == '0);
  assign w_clear_exit = player_at_top || (r_hold >= HOLD_W'(CLEAR_HOLD));
  assign w_half_speed = ((speed >> 1) == 4'd0) ? 4'd1 : (speed >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cooldown  <= '0;
      r_hold      <= '0;
      level_init  <= 1'b0;
      fire_req    <= 1'b0;
      move_en     <= 1'b0;
      win_flight  <= 1'b0;
      speed       <= 4'(START_SPEED);
      level       <= 3'd0;
      bricks_left <= 3'd0;
      score       <= '0;
      gameover    <= 1'b0;
      victory     <= 1'b0;
    end else begin
      level_init <= 1'b0;
      fire_req   <= 1'b0;
      if (game_tick && (r_cooldown != '0)) r_cooldown <= r_cooldown - 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            level_init  <= 1'b1;
            level       <= 3'd1;
            speed       <= 4'(START_SPEED);
            score       <= '0;
            bricks_left <= 3'(NUM_BRICKS);
            victory     <= 1'b0;
            r_cooldown  <= '0;
            move_en     <= 1'b1;
            r_state     <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (w_fire_ok) begin
            fire_req   <= 1'b1;
            r_cooldown <= CD_W'(FIRE_COOLDOWN);
          end
          if (brick_hit) begin
            score <= score_add(score);
            if (bricks_left != 3'd0) bricks_left <= bricks_left - 1'b1;
          end
          // A collision ends the game even when the same cycle clears the last brick.
          if (brick_reached_player) begin
            r_state  <= ST_OVER;
            gameover <= 1'b1;
            move_en  <= 1'b0;
          end else if (brick_hit && (bricks_left <= 3'd1)) begin
            r_state    <= ST_CLEAR;
            move_en    <= 1'b0;
            win_flight <= 1'b1;
            r_hold     <= '0;
          end
        end

        ST_CLEAR: begin
          if (game_tick && (r_hold < HOLD_W'(CLEAR_HOLD))) r_hold <= r_hold + 1'b1;
          if (w_clear_exit) begin
            win_flight <= 1'b0;
            if (level >= 3'(MAX_LEVEL)) begin
              r_state  <= ST_OVER;
              gameover <= 1'b1;
              victory  <= 1'b1;
            end else begin
              level       <= level + 1'b1;
              speed       <= w_half_speed;
              bricks_left <= 3'(NUM_BRICKS);
              level_init  <= 1'b1;
              r_cooldown  <= '0;
              move_en     <= 1'b1;
              r_state     <= ST_PLAY;
            end
          end
        end

        ST_OVER: begin
          if (w_start) begin
            r_state  <= ST_IDLE;
            gameover <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Self-checking bench for brick_game_ctrl: vector table with scoreboard plus directed game sequences.
module tb_brick_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, game_tick, btnS, btnU, brick_hit, brick_reached_player, player_at_top, bullet_active;
  logic [1:0] state;
  logic       level_init, fire_req, move_en, win_flight, gameover, victory;
  logic [3:0] speed;
  logic [2:0] level, bricks_left;
  logic [9:0] score;

  brick_game_ctrl dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .btnS(btnS), .btnU(btnU),
    .brick_hit(brick_hit), .brick_reached_player(brick_reached_player),
    .player_at_top(player_at_top), .bullet_active(bullet_active),
    .state(state), .level_init(level_init), .fire_req(fire_req), .move_en(move_en),
    .win_flight(win_flight), .speed(speed), .level(level), .bricks_left(bricks_left),
    .score(score), .gameover(gameover), .victory(victory)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       reach;
    logic [9:0] exp_score;
    logic [2:0] exp_left;
    logic [1:0] exp_state;
  } vec_t;

  typedef struct packed {
    logic [7:0] idx;
    logic [9:0] exp_score;
    logic [2:0] exp_left;
    logic [1:0] exp_state;
  } sb_t;

  vec_t vecs [6];
  sb_t  sbq [$];
  int   exp_speed [4] = '{6, 3, 1, 1};
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      game_tick = 1'b1;
      cyc(1);
      game_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic hit1();
    brick_hit = 1'b1;
    cyc(1);
    brick_hit = 1'b0;
  endtask

  // Short press: high for three sampling edges, then watch the outputs for five more.
  task automatic press_btn(input bit fire, output int n_init, output int n_fire);
    n_init = 0;
    n_fire = 0;
    if (fire) btnU = 1'b1; else btnS = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k == 3) begin
        if (fire) btnU = 1'b0; else btnS = 1'b0;
      end
      n_init += int'(level_init);
      n_fire += int'(fire_req);
    end
  endtask

  task automatic apply_vec(input int i);
    sb_t e;
    brick_hit            = vecs[i].hit;
    brick_reached_player = vecs[i].reach;
    e.idx       = 8'(i);
    e.exp_score = vecs[i].exp_score;
    e.exp_left  = vecs[i].exp_left;
    e.exp_state = vecs[i].exp_state;
    sbq.push_back(e);
    cyc(1);
    brick_hit            = 1'b0;
    brick_reached_player = 1'b0;
    if (sbq.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      check($sformatf("vec%0d_score", e.idx), int'(score), int'(e.exp_score));
      check($sformatf("vec%0d_left", e.idx), int'(bricks_left), int'(e.exp_left));
      check($sformatf("vec%0d_state", e.idx), int'(state), int'(e.exp_state));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, ni, nf;

    vecs[0] = '{1'b1, 1'b0, 10'd10, 3'd4, 2'd1};
    vecs[1] = '{1'b1, 1'b0, 10'd20, 3'd3, 2'd1};
    vecs[2] = '{1'b1, 1'b0, 10'd30, 3'd2, 2'd1};
    vecs[3] = '{1'b1, 1'b0, 10'd40, 3'd1, 2'd1};
    vecs[4] = '{1'b1, 1'b0, 10'd50, 3'd0, 2'd2};
    vecs[5] = '{1'b1, 1'b1, 10'd60, 3'd4, 2'd3};

    rst = 1'b1; game_tick = 1'b0; btnS = 1'b0; btnU = 1'b0; brick_hit = 1'b0;
    brick_reached_player = 1'b0; player_at_top = 1'b0; bullet_active = 1'b0;
    cyc(3);
    check("rst_state", int'(state), 0);
    check("rst_level", int'(level), 0);
    check("rst_left", int'(bricks_left), 0);
    check("rst_score", int'(score), 0);
    check("rst_speed", int'(speed), 6);
    check("rst_flags", int'({level_init, fire_req, move_en, win_flight, gameover, victory}), 0);
    rst = 1'b0;
    cyc(2);

    // Start button held ten cycles: one level_init, on the fourth edge after the press.
    btnS = 1'b1; cnt = 0; first = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (level_init) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 10) btnS = 1'b0;
    end
    check("start_init_count", cnt, 1);
    check("start_init_edge", first, 4);
    check("start_state", int'(state), 1);
    check("start_level", int'(level), 1);
    check("start_left", int'(bricks_left), 5);
    check("start_speed", int'(speed), 6);
    check("start_score", int'(score), 0);
    check("start_move_en", int'(move_en), 1);

    // Firing: accepted, then blocked by cooldown, then by a live bullet, then accepted.
    press_btn(1'b1, ni, nf);
    check("fire1", nf, 1);
    press_btn(1'b1, ni, nf);
    check("fire_cooldown", nf, 0);
    ticks(16);
    bullet_active = 1'b1;
    press_btn(1'b1, ni, nf);
    check("fire_bullet_active", nf, 0);
    bullet_active = 1'b0;
    press_btn(1'b1, ni, nf);
    check("fire_after_cooldown", nf, 1);

    for (int i = 0; i < 5; i++) apply_vec(i);
    check("clear_win_flight", int'(win_flight), 1);
    check("clear_move_en", int'(move_en), 0);

    player_at_top = 1'b1;
    cyc(1);
    player_at_top = 1'b0;
    check("lv2_level", int'(level), 2);
    check("lv2_speed", int'(speed), 3);
    check("lv2_init", int'(level_init), 1);
    check("lv2_state", int'(state), 1);
    check("lv2_left", int'(bricks_left), 5);
    check("lv2_win_flight", int'(win_flight), 0);

    // Hit and collision together: scored, but the collision wins.
    apply_vec(5);
    check("over_gameover", int'(gameover), 1);
    check("over_victory", int'(victory), 0);
    check("over_move_en", int'(move_en), 0);
    press_btn(1'b0, ni, nf);
    check("over_to_idle", int'(state), 0);
    check("idle_score_held", int'(score), 60);

    // Full game with CLEAR timeouts only.
    press_btn(1'b0, ni, nf);
    check("g2_state", int'(state), 1);
    check("g2_score", int'(score), 0);
    for (int lv = 1; lv <= 4; lv++) begin
      check($sformatf("lv%0d_speed", lv), int'(speed), exp_speed[lv-1]);
      check($sformatf("lv%0d_level", lv), int'(level), lv);
      repeat (5) hit1();
      check($sformatf("lv%0d_clear", lv), int'(state), 2);
      ticks(119);
      check($sformatf("lv%0d_hold_early", lv), int'(state), 2);
      ticks(1);
      for (int w = 0; w < 10 && state == 2'd2; w++) cyc(1);
      if (lv < 4) check($sformatf("lv%0d_exit", lv), int'(state), 1);
    end
    check("win_state", int'(state), 3);
    check("win_victory", int'(victory), 1);
    check("win_gameover", int'(gameover), 1);
    check("win_score", int'(score), 200);

    // Score saturation near the top of the range.
    press_btn(1'b0, ni, nf);
    press_btn(1'b0, ni, nf);
    check("g3_state", int'(state), 1);
    @(negedge clk);
    force dut.score = 10'd1020;
    #1;
    release dut.score;
    hit1();
    check("sat_score1", int'(score), 1023);
    check("sat_left1", int'(bricks_left), 4);
    hit1();
    check("sat_score2", int'(score), 1023);

    // Reset in CLEAR with fire held.
    repeat (3) hit1();
    check("pre_rst_clear", int'(state), 2);
    btnU = 1'b1;
    rst  = 1'b1;
    cyc(1);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_speed", int'(speed), 6);
    check("mid_rst_left", int'(bricks_left), 0);
    check("mid_rst_flags", int'({level_init, fire_req, move_en, win_flight, gameover, victory}), 0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      cnt += int'(fire_req);
    end
    btnU = 1'b0;
    check("post_rst_no_fire", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
